// File: rtl/gem_pkg.sv
// Shared types, constants and BCD helper for the gem collection engine.
package gem_pkg;

    typedef enum logic [1:0] {
        ANY  = 2'd0,
        FIRE = 2'd1,
        ICE  = 2'd2
    } gem_kind_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int unsigned ADDR_W = 9;

    // Adds one to the low `digits` BCD digits of v; all-nines stays put.
    function automatic logic [31:0] bcd_inc_sat(input logic [31:0] v, input int unsigned digits);
        logic [31:0] r;
        logic        carry;
        logic        sat;
        r     = v;
        carry = 1'b1;
        sat   = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < digits && v[4*i +: 4] != 4'd9) sat = 1'b0;
        end
        if (!sat) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (i < digits && carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gem_tracker_bcd_score_counter.sv
// Saturating BCD score register with synchronous clear.
module bcd_score_counter
    import gem_pkg::*;
#(
    parameter int unsigned SCORE_DIGITS = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      clear,
    input  logic                      inc,
    output logic [4*SCORE_DIGITS-1:0] value
);

    logic [4*SCORE_DIGITS-1:0] value_q, value_d;
    logic [31:0]               next_full;

    always_comb begin
        next_full = bcd_inc_sat(32'(value_q), SCORE_DIGITS);
        value_d   = value_q;
        if (clear)    value_d = '0;
        else if (inc) value_d = next_full[4*SCORE_DIGITS-1:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/gem_tracker.sv
// Per-frame gem scan against both player boxes, collection latching,
// per-player scoring and the combinational per-pixel gem layer.
module gem_tracker
    import gem_pkg::*;
#(
    parameter int unsigned            NUM_GEMS     = 8,
    parameter int unsigned            GEM_W        = 24,
    parameter int unsigned            GEM_H        = 19,
    parameter int unsigned            SCORE_DIGITS = 2,
    parameter logic [16*NUM_GEMS-1:0] GEM_X        = '0,
    parameter logic [16*NUM_GEMS-1:0] GEM_Y        = '0,
    parameter logic [2*NUM_GEMS-1:0]  GEM_KIND     = '0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      clear,
    input  logic                      frame_start,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic signed [15:0]        player1_top,
    input  logic signed [15:0]        player1_bottom,
    input  logic signed [15:0]        player1_left,
    input  logic signed [15:0]        player1_right,
    input  logic signed [15:0]        player2_top,
    input  logic signed [15:0]        player2_bottom,
    input  logic signed [15:0]        player2_left,
    input  logic signed [15:0]        player2_right,
    output logic                      is_gem,
    output logic [1:0]                gem_kind,
    output logic [ADDR_W-1:0]         gem_rom_addr,
    output logic [NUM_GEMS-1:0]       collected,
    output logic                      all_collected,
    output logic [4*SCORE_DIGITS-1:0] p1_score,
    output logic [4*SCORE_DIGITS-1:0] p2_score,
    output logic                      collect_pulse,
    output logic                      collect_player,
    output logic                      scan_busy
);

    localparam int unsigned       IDX_W = (NUM_GEMS > 1) ? $clog2(NUM_GEMS) : 1;
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_GEMS - 1);
    localparam logic signed [15:0] GW16 = 16'(GEM_W);
    localparam logic signed [15:0] GH16 = 16'(GEM_H);
    localparam logic [9:0]        GW10  = 10'(GEM_W);
    localparam logic [9:0]        GH10  = 10'(GEM_H);

    logic signed [15:0] gx_a [NUM_GEMS];
    logic signed [15:0] gy_a [NUM_GEMS];
    gem_kind_t          gk_a [NUM_GEMS];

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_GEMS-1:0] coll_q, coll_d;
    logic                all_q;
    logic                pulse_q, pulse_d;
    logic                player_q, player_d;
    logic                inc1, inc2;

    logic signed [15:0]  cur_x, cur_y;
    logic                hit1, hit2;

    always_comb begin
        for (int unsigned i = 0; i < NUM_GEMS; i++) begin
            gx_a[i] = GEM_X[16*i +: 16];
            gy_a[i] = GEM_Y[16*i +: 16];
            gk_a[i] = gem_kind_t'(GEM_KIND[2*i +: 2]);
        end
    end

    assign cur_x = gx_a[idx_q];
    assign cur_y = gy_a[idx_q];
    assign hit1  = (player1_right > cur_x) && (player1_left < cur_x + GW16) &&
                   (player1_bottom > cur_y) && (player1_top < cur_y + GH16);
    assign hit2  = (player2_right > cur_x) && (player2_left < cur_x + GW16) &&
                   (player2_bottom > cur_y) && (player2_top < cur_y + GH16);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        coll_d   = coll_q;
        pulse_d  = 1'b0;
        player_d = player_q;
        inc1     = 1'b0;
        inc2     = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                // Player 1 is tested first so it wins shared gems.
                if (!coll_q[idx_q]) begin
                    if (hit1 && gk_a[idx_q] != ICE) begin
                        coll_d[idx_q] = 1'b1;
                        pulse_d       = 1'b1;
                        player_d      = 1'b0;
                        inc1          = 1'b1;
                    end else if (hit2 && gk_a[idx_q] != FIRE) begin
                        coll_d[idx_q] = 1'b1;
                        pulse_d       = 1'b1;
                        player_d      = 1'b1;
                        inc2          = 1'b1;
                    end
                end
                if (idx_q == LAST) state_d = IDLE;
                else               idx_d   = idx_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d  = IDLE;
            idx_d    = '0;
            coll_d   = '0;
            pulse_d  = 1'b0;
            player_d = 1'b0;
            inc1     = 1'b0;
            inc2     = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            coll_q   <= '0;
            all_q    <= 1'b0;
            pulse_q  <= 1'b0;
            player_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            coll_q   <= coll_d;
            all_q    <= clear ? 1'b0 : &coll_q;
            pulse_q  <= pulse_d;
            player_q <= player_d;
        end
    end

    bcd_score_counter #(.SCORE_DIGITS(SCORE_DIGITS)) u_p1_score (
        .Clk(Clk), .Reset(Reset), .clear(clear), .inc(inc1), .value(p1_score)
    );

    bcd_score_counter #(.SCORE_DIGITS(SCORE_DIGITS)) u_p2_score (
        .Clk(Clk), .Reset(Reset), .clear(clear), .inc(inc2), .value(p2_score)
    );

    logic [9:0] ox, oy, addr_full;
    logic       px_hit;
    gem_kind_t  px_kind;

    // Offsets wrap as unsigned, so pixels left of / above a gem fail the range check.
    always_comb begin
        px_hit    = 1'b0;
        px_kind   = ANY;
        addr_full = '0;
        ox        = '0;
        oy        = '0;
        for (int unsigned i = 0; i < NUM_GEMS; i++) begin
            ox = DrawX - gx_a[i][9:0];
            oy = DrawY - gy_a[i][9:0];
            if (!px_hit && !coll_q[i] && ox < GW10 && oy < GH10) begin
                px_hit    = 1'b1;
                px_kind   = gk_a[i];
                addr_full = oy * GW10 + ox;
            end
        end
    end

    assign is_gem         = px_hit;
    assign gem_kind       = px_kind;
    assign gem_rom_addr   = addr_full[ADDR_W-1:0];
    assign collected      = coll_q;
    assign all_collected  = all_q;
    assign collect_pulse  = pulse_q;
    assign collect_player = player_q;
    assign scan_busy      = (state_q == SCAN);

endmodule

// File: tb/tb_gem_tracker.sv
// Directed bench for gem_tracker with a frame-level reference model.
module tb_gem_tracker;
    import gem_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clr, fs, fsb;
    logic [9:0] dx, dy;
    logic signed [15:0] p1t, p1b, p1l, p1r, p2t, p2b, p2l, p2r;
    logic signed [15:0] q1t, q1b, q1l, q1r;

    logic        is_gem, all_c, pulse, player, busy;
    logic [1:0]  kind;
    logic [8:0]  addr;
    logic [7:0]  coll, s1, s2;

    logic        is_gem_b, all_b, pulse_b, player_b, busy_b;
    logic [1:0]  kind_b;
    logic [8:0]  addr_b;
    logic [11:0] coll_b;
    logic [7:0]  s1_b, s2_b;

    logic        is_gem_c, all_cc, pulse_c, player_c, busy_c;
    logic [1:0]  kind_c;
    logic [8:0]  addr_c;
    logic [11:0] coll_cc;
    logic [3:0]  s1_c, s2_c;

    gem_tracker #(
        .NUM_GEMS(8), .GEM_W(24), .GEM_H(19), .SCORE_DIGITS(2),
        .GEM_X({16'd200, 16'd700, 16'd50, 16'd600, 16'd500, 16'd100, 16'd400, 16'd300}),
        .GEM_Y({16'd10, 16'd400, 16'd400, 16'd300, 16'd100, 16'd200, 16'd50, 16'd300}),
        .GEM_KIND({2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0})
    ) dut (
        .Clk(clk), .Reset(rst), .clear(clr), .frame_start(fs), .DrawX(dx), .DrawY(dy),
        .player1_top(p1t), .player1_bottom(p1b), .player1_left(p1l), .player1_right(p1r),
        .player2_top(p2t), .player2_bottom(p2b), .player2_left(p2l), .player2_right(p2r),
        .is_gem(is_gem), .gem_kind(kind), .gem_rom_addr(addr), .collected(coll),
        .all_collected(all_c), .p1_score(s1), .p2_score(s2), .collect_pulse(pulse),
        .collect_player(player), .scan_busy(busy)
    );

    gem_tracker #(
        .NUM_GEMS(12), .GEM_W(24), .GEM_H(19), .SCORE_DIGITS(2),
        .GEM_X('0), .GEM_Y('0), .GEM_KIND({12{2'd1}})
    ) dut_b (
        .Clk(clk), .Reset(rst), .clear(1'b0), .frame_start(fsb), .DrawX(dx), .DrawY(dy),
        .player1_top(q1t), .player1_bottom(q1b), .player1_left(q1l), .player1_right(q1r),
        .player2_top(-16'sd200), .player2_bottom(-16'sd190), .player2_left(-16'sd200), .player2_right(-16'sd190),
        .is_gem(is_gem_b), .gem_kind(kind_b), .gem_rom_addr(addr_b), .collected(coll_b),
        .all_collected(all_b), .p1_score(s1_b), .p2_score(s2_b), .collect_pulse(pulse_b),
        .collect_player(player_b), .scan_busy(busy_b)
    );

    gem_tracker #(
        .NUM_GEMS(12), .GEM_W(24), .GEM_H(19), .SCORE_DIGITS(1),
        .GEM_X('0), .GEM_Y('0), .GEM_KIND({12{2'd1}})
    ) dut_c (
        .Clk(clk), .Reset(rst), .clear(1'b0), .frame_start(fsb), .DrawX(dx), .DrawY(dy),
        .player1_top(q1t), .player1_bottom(q1b), .player1_left(q1l), .player1_right(q1r),
        .player2_top(-16'sd200), .player2_bottom(-16'sd190), .player2_left(-16'sd200), .player2_right(-16'sd190),
        .is_gem(is_gem_c), .gem_kind(kind_c), .gem_rom_addr(addr_c), .collected(coll_cc),
        .all_collected(all_cc), .p1_score(s1_c), .p2_score(s2_c), .collect_pulse(pulse_c),
        .collect_player(player_c), .scan_busy(busy_c)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: gem table, collected set, integer scores.
    int mx [N] = '{300, 400, 100, 500, 600, 50, 700, 200};
    int my [N] = '{300, 50, 200, 100, 300, 400, 400, 10};
    int mk [N] = '{0, 2, 1, 1, 0, 2, 0, 2};   // 0 any, 1 fire, 2 ice
    bit mcol [N];
    int ms1, ms2, mpos;
    bit mscan, mpulse, mplayer, mall;

    function automatic logic [7:0] bcd2(input int n);
        int s;
        s = (n > 99) ? 99 : n;
        return 8'((s / 10) * 16 + s % 10);
    endfunction

    function automatic bit ovl(input int t, input int b, input int l, input int r, input int g);
        return (r > mx[g]) && (l < mx[g] + 24) && (b > my[g]) && (t < my[g] + 19);
    endfunction

    initial begin
        bit         oldall;
        logic [7:0] mc;
        int         ox, oy, eh, ek, ea;
        forever begin
            @(posedge clk);
            if (rst || clr) begin
                for (int g = 0; g < N; g++) mcol[g] = 1'b0;
                ms1 = 0; ms2 = 0; mscan = 1'b0; mpos = 0;
                mpulse = 1'b0; mplayer = 1'b0; mall = 1'b0;
            end else begin
                oldall = 1'b1;
                for (int g = 0; g < N; g++) if (!mcol[g]) oldall = 1'b0;
                mpulse = 1'b0;
                if (mscan) begin
                    if (!mcol[mpos]) begin
                        if (mk[mpos] != 2 && ovl(int'(p1t), int'(p1b), int'(p1l), int'(p1r), mpos)) begin
                            mcol[mpos] = 1'b1; ms1++; mpulse = 1'b1; mplayer = 1'b0;
                        end else if (mk[mpos] != 1 && ovl(int'(p2t), int'(p2b), int'(p2l), int'(p2r), mpos)) begin
                            mcol[mpos] = 1'b1; ms2++; mpulse = 1'b1; mplayer = 1'b1;
                        end
                    end
                    mpos++;
                    if (mpos == N) mscan = 1'b0;
                end else if (fs) begin
                    mscan = 1'b1;
                    mpos  = 0;
                end
                mall = oldall;
            end
            #1;
            for (int g = 0; g < N; g++) mc[g] = mcol[g];
            chk("busy", 32'(busy), 32'(mscan));
            chk("collected", 32'(coll), 32'(mc));
            chk("all_collected", 32'(all_c), 32'(mall));
            chk("p1_score", 32'(s1), 32'(bcd2(ms1)));
            chk("p2_score", 32'(s2), 32'(bcd2(ms2)));
            chk("collect_pulse", 32'(pulse), 32'(mpulse));
            if (mpulse) chk("collect_player", 32'(player), 32'(mplayer));
            eh = 0; ek = 0; ea = 0;
            for (int g = N - 1; g >= 0; g--) begin
                ox = int'(dx) - mx[g];
                oy = int'(dy) - my[g];
                if (!mcol[g] && ox >= 0 && ox < 24 && oy >= 0 && oy < 19) begin
                    eh = 1; ek = mk[g]; ea = oy * 24 + ox;
                end
            end
            chk("is_gem", 32'(is_gem), 32'(eh));
            chk("gem_kind", 32'(kind), 32'(ek));
            chk("gem_rom_addr", 32'(addr), 32'(ea));
        end
    end

    task automatic set_p1(input int t, input int b, input int l, input int r);
        p1t = 16'(t); p1b = 16'(b); p1l = 16'(l); p1r = 16'(r);
    endtask

    task automatic set_p2(input int t, input int b, input int l, input int r);
        p2t = 16'(t); p2b = 16'(b); p2l = 16'(l); p2r = 16'(r);
    endtask

    task automatic run_frame(output int pulses);
        pulses = 0;
        @(negedge clk) fs = 1'b1;
        @(negedge clk) fs = 1'b0;
        repeat (N + 2) begin
            if (pulse) pulses++;
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int busy_cnt, np;
        rst = 1'b1; clr = 1'b0; fs = 1'b0; fsb = 1'b0; dx = '0; dy = '0;
        set_p1(-200, -190, -200, -190);
        set_p2(-200, -190, -200, -190);
        q1t = -16'sd200; q1b = -16'sd190; q1l = -16'sd200; q1r = -16'sd190;
        repeat (3) @(negedge clk);
        chk("rst_p1", 32'(s1), 32'h00);
        chk("rst_collected", 32'(coll), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pulse", 32'(pulse), 32'h0);
        rst = 1'b0;

        // Three idle frames; a frame_start inside the third scan is ignored.
        for (int f = 0; f < 3; f++) begin
            busy_cnt = 0;
            @(negedge clk) fs = 1'b1;
            @(negedge clk) fs = 1'b0;
            for (int i = 0; i < N + 4; i++) begin
                if (busy) busy_cnt++;
                if (f == 2 && i == 3) fs = 1'b1;
                if (f == 2 && i == 4) fs = 1'b0;
                @(negedge clk);
            end
            chk("busy_len", 32'(busy_cnt), 32'd8);
        end
        chk("idle_p1", 32'(s1), 32'h00);
        chk("idle_collected", 32'(coll), 32'h00);

        dx = 10'd103; dy = 10'd202;
        #1;
        chk("probe_hit", 32'(is_gem), 32'h1);
        chk("probe_addr", 32'(addr), 32'd51);
        chk("probe_kind", 32'(kind), 32'd1);

        // Player 1 overlaps fire gem 2 by one pixel.
        set_p1(190, 205, 80, 101);
        @(negedge clk) fs = 1'b1;
        @(negedge clk) fs = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("g2_not_yet", 32'(coll[2]), 32'h0);
        @(posedge clk); #1;
        chk("g2_latched", 32'(coll[2]), 32'h1);
        chk("g2_pulse", 32'(pulse), 32'h1);
        chk("g2_player", 32'(player), 32'h0);
        chk("g2_p1", 32'(s1), 32'h01);
        chk("probe_after", 32'(is_gem), 32'h0);
        repeat (N) @(negedge clk);
        run_frame(np);
        chk("refrm_pulses", 32'(np), 32'd0);
        chk("refrm_p1", 32'(s1), 32'h01);

        // Edge contact and wrong-player contact on fire gem 3.
        set_p1(95, 110, 480, 500);
        set_p2(95, 110, 490, 510);
        run_frame(np);
        chk("touch_collected", 32'(coll), 32'h04);
        set_p1(-200, -190, -200, -190);
        set_p2(395, 410, 40, 60);
        run_frame(np);
        chk("ice_p2", 32'(s2), 32'h01);
        chk("ice_collected", 32'(coll), 32'h24);

        // Both players on shared gem 0.
        set_p1(290, 310, 290, 310);
        set_p2(290, 310, 290, 310);
        run_frame(np);
        chk("any_pulses", 32'(np), 32'd1);
        chk("any_p1", 32'(s1), 32'h02);
        chk("any_p2", 32'(s2), 32'h01);

        set_p1(95, 110, 490, 510);
        set_p2(45, 60, 390, 410);
        run_frame(np);
        chk("rest1_coll", 32'(coll), 32'h2f);
        set_p1(295, 310, 590, 610);
        set_p2(5, 20, 190, 210);
        run_frame(np);
        chk("rest2_coll", 32'(coll), 32'hbf);
        chk("rest2_p2", 32'(s2), 32'h03);
        set_p1(395, 410, 690, 710);
        set_p2(-200, -190, -200, -190);
        @(negedge clk) fs = 1'b1;
        @(negedge clk) fs = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("last_bit", 32'(coll), 32'hff);
        chk("all_lag", 32'(all_c), 32'h0);
        @(posedge clk); #1;
        chk("all_high", 32'(all_c), 32'h1);
        chk("final_p1", 32'(s1), 32'h05);
        repeat (3) @(negedge clk);

        // Clear mid-scan, then clear colliding with frame_start.
        @(negedge clk) fs = 1'b1;
        @(negedge clk) fs = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        chk("clr_busy", 32'(busy), 32'h0);
        chk("clr_p1", 32'(s1), 32'h00);
        chk("clr_coll", 32'(coll), 32'h00);
        chk("clr_all", 32'(all_c), 32'h0);
        chk("clr_probe", 32'(is_gem), 32'h1);
        fs = 1'b1; clr = 1'b1;
        @(negedge clk) fs = 1'b0; clr = 1'b0;
        chk("clr_beats_fs", 32'(busy), 32'h0);

        // Async reset mid-scan after gem 0 has scored.
        set_p1(290, 310, 290, 310);
        @(negedge clk) fs = 1'b1;
        @(negedge clk) fs = 1'b0;
        @(negedge clk);
        chk("pre_rst_p1", 32'(s1), 32'h01);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_p1", 32'(s1), 32'h00);
        chk("mid_rst_coll", 32'(coll), 32'h00);
        @(negedge clk) rst = 1'b0;
        run_frame(np);
        chk("post_rst_p1", 32'(s1), 32'h01);

        // Twelve fire gems at the origin: BCD carry and single-digit saturation.
        q1t = -16'sd5; q1b = 16'sd5; q1l = -16'sd5; q1r = 16'sd5;
        @(negedge clk) fsb = 1'b1;
        @(negedge clk) fsb = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("b_nine", 32'(s1_b), 32'h09);
        chk("c_nine", 32'(s1_c), 32'h9);
        @(posedge clk); #1;
        chk("b_carry", 32'(s1_b), 32'h10);
        chk("c_sat", 32'(s1_c), 32'h9);
        repeat (5) @(negedge clk);
        chk("b_final", 32'(s1_b), 32'h12);
        chk("c_final", 32'(s1_c), 32'h9);
        chk("b_coll", 32'(coll_b), 32'hfff);
        chk("c_all", 32'(all_cc), 32'h1);
        chk("b_p2", 32'(s2_b), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
